// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island constants and the serial BCH step.
// Used by the packet assembler and its ECC generators.
package hdmi_pkg;

    localparam logic [7:0] BCH_POLY = 8'h83;
    localparam int PACKET_LEN = 32;
    localparam int HEADER_BITS = 24;
    localparam int SUB_BITS = 56;
    localparam int NUM_SUB = 4;

    // One LSB-first step of the BCH LFSR for G(x)=1+x^6+x^7+x^8.
    function automatic logic [7:0] bch_step(
        input logic [7:0] e,
        input logic d
    );
        logic fb;
        fb = d ^ e[0];
        return (e >> 1) ^ (fb ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/bch_ecc_step.sv
// Serial BCH ECC register taking BITS data bits per cycle, LSB first.
// start seeds the step from zero so the first bit lands on a clean LFSR.
module bch_ecc_step
    import hdmi_pkg::*;
#(
    parameter int BITS = 1
) (
    input  logic            clk_pixel,
    input  logic            reset,
    input  logic            start,
    input  logic            advance,
    input  logic            abort,
    input  logic [BITS-1:0] d,
    output logic [7:0]      ecc
);

    logic [7:0] base;
    logic [7:0] next;

    always_comb begin
        base = start ? 8'h00 : ecc;
        next = base;
        for (int i = 0; i < BITS; i++) begin
            next = bch_step(next, d[i]);
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            ecc <= 8'h00;
        end else if (abort) begin
            ecc <= 8'h00;
        end else if (advance) begin
            ecc <= next;
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// Serialises a captured HDMI data-island packet into 32 TERC4-ready
// bit-groups, appending BCH ECC to the header and each subpacket.
module packet_assembler
    import hdmi_pkg::*;
(
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic             packet_enable,
    output logic             packet_valid,
    output logic [8:0]       packet_data,
    output logic             packet_end
);

    localparam logic [4:0] HDR_END = 5'(HEADER_BITS);
    localparam logic [4:0] SUB_END = 5'(SUB_BITS / 2);
    localparam logic [4:0] LAST_IDX = 5'(PACKET_LEN - 1);

    logic [4:0]       idx;
    logic [23:0]      hdr_q;
    logic [3:0][55:0] sub_q;
    logic [23:0]      hdr_src;
    logic [3:0][55:0] sub_src;
    logic             hdr_adv;
    logic             sub_adv;
    logic             abort;
    logic             hdr_d;
    logic [3:0][1:0]  sub_d;
    logic [7:0]       hdr_ecc;
    logic [3:0][7:0]  sub_ecc;
    logic             ch0;
    logic [3:0]       ch1;
    logic [3:0]       ch2;

    assign packet_enable = data_island_period && (idx == 5'd0) && !reset;
    assign abort = !data_island_period;
    assign hdr_adv = data_island_period && (idx < HDR_END);
    assign sub_adv = data_island_period && (idx < SUB_END);

    // Index 0 serialises straight from the inputs being captured.
    assign hdr_src = packet_enable ? header : hdr_q;
    assign sub_src = packet_enable ? sub : sub_q;

    assign hdr_d = hdr_src[idx];

    always_comb begin
        for (int j = 0; j < NUM_SUB; j++) begin
            sub_d[j][0] = sub_src[j][{idx, 1'b0}];
            sub_d[j][1] = sub_src[j][{idx, 1'b1}];
        end
    end

    bch_ecc_step #(.BITS(1)) u_hdr_ecc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .start     (packet_enable),
        .advance   (hdr_adv),
        .abort     (abort),
        .d         (hdr_d),
        .ecc       (hdr_ecc)
    );

    for (genvar j = 0; j < NUM_SUB; j++) begin : g_sub_ecc
        bch_ecc_step #(.BITS(2)) u_sub_ecc (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .start     (packet_enable),
            .advance   (sub_adv),
            .abort     (abort),
            .d         (sub_d[j]),
            .ecc       (sub_ecc[j])
        );
    end

    always_comb begin
        ch0 = (idx < HDR_END) ? hdr_d : hdr_ecc[idx[2:0]];
        for (int j = 0; j < NUM_SUB; j++) begin
            if (idx < SUB_END) begin
                ch1[j] = sub_d[j][0];
                ch2[j] = sub_d[j][1];
            end else begin
                ch1[j] = sub_ecc[j][{idx[1:0], 1'b0}];
                ch2[j] = sub_ecc[j][{idx[1:0], 1'b1}];
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            idx <= 5'd0;
        end else if (data_island_period) begin
            idx <= idx + 5'd1;
        end else begin
            idx <= 5'd0;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            hdr_q <= '0;
            sub_q <= '0;
        end else if (packet_enable) begin
            hdr_q <= header;
            sub_q <= sub;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            packet_valid <= 1'b0;
            packet_data  <= 9'd0;
            packet_end   <= 1'b0;
        end else if (data_island_period) begin
            packet_valid <= 1'b1;
            packet_data  <= {ch2, ch1, ch0};
            packet_end   <= (idx == LAST_IDX);
        end else begin
            packet_valid <= 1'b0;
            packet_data  <= 9'd0;
            packet_end   <= 1'b0;
        end
    end

endmodule
